// File: rtl/cache_miss_controller.sv
// Cache miss controller: sequences hit completion, dirty-victim writeback, line fill and
// write-through stores around a word-serial higher-memory port.
module cache_miss_controller #(
   parameter int unsigned WORDS_PER_BLOCK = 4,
   parameter int unsigned WRITE_THROUGH   = 0,
   localparam int unsigned CW             = $clog2(WORDS_PER_BLOCK)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   input  logic          req_op,
   output logic          req_ready,
   input  logic          valid_block_match,
   input  logic          valid_dirty_bit,
   output logic          hmem_req_valid,
   output logic          hmem_req_op,
   input  logic          hmem_ready,
   output logic [CW-1:0] word_index,
   output logic          miss_recovery_mode,
   output logic          clear_selected_dirty_bit,
   output logic          set_selected_dirty_bit,
   output logic          perform_write,
   output logic          clear_selected_valid_bit,
   output logic          finish_new_line_install,
   output logic          set_hmem_block_address,
   output logic          use_victim_tag_for_hmem_block_address,
   output logic          busy
);

   localparam logic [CW-1:0] CntMax = CW'(WORDS_PER_BLOCK - 1);

   typedef enum logic [2:0] {
      StIdle,
      StCompare,
      StWriteback,
      StFill,
      StInstall,
      StWtWrite
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign word_index = cnt_q;

   always_comb begin
      state_d                               = state_q;
      cnt_d                                 = cnt_q;
      req_ready                             = 1'b0;
      hmem_req_valid                        = 1'b0;
      hmem_req_op                           = 1'b0;
      miss_recovery_mode                    = 1'b0;
      clear_selected_dirty_bit              = 1'b0;
      set_selected_dirty_bit                = 1'b0;
      perform_write                         = 1'b0;
      clear_selected_valid_bit              = 1'b0;
      finish_new_line_install               = 1'b0;
      set_hmem_block_address                = 1'b0;
      use_victim_tag_for_hmem_block_address = 1'b0;
      busy                                  = (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            if (req_valid) state_d = StCompare;
         end
         StCompare: begin
            if (valid_block_match) begin
               if (!req_op) begin
                  req_ready = 1'b1;
                  state_d   = StIdle;
               end else if (WRITE_THROUGH != 0) begin
                  perform_write = 1'b1;
                  state_d       = StWtWrite;
               end else begin
                  perform_write          = 1'b1;
                  set_selected_dirty_bit = 1'b1;
                  req_ready              = 1'b1;
                  state_d                = StIdle;
               end
            end else if ((WRITE_THROUGH == 0) && valid_dirty_bit) begin
               set_hmem_block_address                = 1'b1;
               use_victim_tag_for_hmem_block_address = 1'b1;
               cnt_d                                 = CntMax;
               state_d                               = StWriteback;
            end else begin
               set_hmem_block_address   = 1'b1;
               clear_selected_valid_bit = 1'b1;
               cnt_d                    = CntMax;
               state_d                  = StFill;
            end
         end
         StWriteback: begin
            miss_recovery_mode = 1'b1;
            hmem_req_valid     = 1'b1;
            hmem_req_op        = 1'b1;
            if (hmem_ready) begin
               if (cnt_q == '0) begin
                  // Victim fully written: retarget the address at the missing line.
                  clear_selected_dirty_bit = 1'b1;
                  set_hmem_block_address   = 1'b1;
                  clear_selected_valid_bit = 1'b1;
                  cnt_d                    = CntMax;
                  state_d                  = StFill;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         StFill: begin
            miss_recovery_mode = 1'b1;
            hmem_req_valid     = 1'b1;
            if (hmem_ready) begin
               if (cnt_q == '0) state_d = StInstall;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         StInstall: begin
            finish_new_line_install = 1'b1;
            state_d                 = StCompare;
         end
         StWtWrite: begin
            hmem_req_valid = 1'b1;
            hmem_req_op    = 1'b1;
            if (hmem_ready) begin
               req_ready = 1'b1;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_cache_miss_controller.sv
// Bench for cache_miss_controller: directed and random transactions on a write-back and a
// write-through instance, scored against transaction-level expectations.
module tb_cache_miss_controller;

   localparam int unsigned WPB = 4;
   localparam int unsigned CW  = 2;

   typedef struct packed {
      logic          req_ready;
      logic          hrv;
      logic          hop;
      logic [CW-1:0] widx;
      logic          mrm;
      logic          clr_dirty;
      logic          set_dirty;
      logic          pw;
      logic          clr_valid;
      logic          fin;
      logic          set_addr;
      logic          use_victim;
      logic          busy;
   } outs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic  rst_n, sel, req_valid, req_op, match, dirty, hmem_ready;
   outs_t o_wb, o_wt, o;
   int    ntests = 0;
   int    nfail  = 0;

   cache_miss_controller #(.WORDS_PER_BLOCK(WPB), .WRITE_THROUGH(0)) dut_wb (
      .clk                                   (clk),
      .rst_n                                 (rst_n),
      .req_valid                             (req_valid & ~sel),
      .req_op                                (req_op),
      .req_ready                             (o_wb.req_ready),
      .valid_block_match                     (match),
      .valid_dirty_bit                       (dirty),
      .hmem_req_valid                        (o_wb.hrv),
      .hmem_req_op                           (o_wb.hop),
      .hmem_ready                            (hmem_ready & ~sel),
      .word_index                            (o_wb.widx),
      .miss_recovery_mode                    (o_wb.mrm),
      .clear_selected_dirty_bit              (o_wb.clr_dirty),
      .set_selected_dirty_bit                (o_wb.set_dirty),
      .perform_write                         (o_wb.pw),
      .clear_selected_valid_bit              (o_wb.clr_valid),
      .finish_new_line_install               (o_wb.fin),
      .set_hmem_block_address                (o_wb.set_addr),
      .use_victim_tag_for_hmem_block_address (o_wb.use_victim),
      .busy                                  (o_wb.busy)
   );

   cache_miss_controller #(.WORDS_PER_BLOCK(WPB), .WRITE_THROUGH(1)) dut_wt (
      .clk                                   (clk),
      .rst_n                                 (rst_n),
      .req_valid                             (req_valid & sel),
      .req_op                                (req_op),
      .req_ready                             (o_wt.req_ready),
      .valid_block_match                     (match),
      .valid_dirty_bit                       (dirty),
      .hmem_req_valid                        (o_wt.hrv),
      .hmem_req_op                           (o_wt.hop),
      .hmem_ready                            (hmem_ready & sel),
      .word_index                            (o_wt.widx),
      .miss_recovery_mode                    (o_wt.mrm),
      .clear_selected_dirty_bit              (o_wt.clr_dirty),
      .set_selected_dirty_bit                (o_wt.set_dirty),
      .perform_write                         (o_wt.pw),
      .clear_selected_valid_bit              (o_wt.clr_valid),
      .finish_new_line_install               (o_wt.fin),
      .set_hmem_block_address                (o_wt.set_addr),
      .use_victim_tag_for_hmem_block_address (o_wt.use_victim),
      .busy                                  (o_wt.busy)
   );

   assign o = sel ? o_wt : o_wb;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One CPU request; higher memory answers each word after `stall` wait cycles.
   task automatic run_txn(input string tag, input bit wt, input bit op, input bit hit,
                          input bit dty, input int stall);
      logic [CW:0] exp_x[$];
      logic [CW:0] got_x[$];
      int n_busy = 0, n_mrm = 0, n_ready = 0, n_pw = 0, n_sd = 0, n_cd = 0;
      int n_cv = 0, n_fin = 0, n_sa = 0, n_uv = 0;
      int wait_cnt = 0, cyc = 0, nxm, busy_exp;
      bit got_ready = 0, saw_fin = 0, first_busy = 0, miss, dwb;

      miss = !hit;
      dwb  = miss && dty && !wt;
      if (dwb) for (int i = WPB - 1; i >= 0; i--) exp_x.push_back({1'b1, CW'(i)});
      if (miss) for (int i = WPB - 1; i >= 0; i--) exp_x.push_back({1'b0, CW'(i)});
      if (wt && op) exp_x.push_back({1'b1, CW'(0)});
      nxm      = miss ? (dwb ? 2 : 1) * WPB : 0;
      busy_exp = 1 + (miss ? nxm * (stall + 1) + 2 : 0) + ((wt && op) ? stall + 1 : 0);

      sel        = wt;
      req_op     = op;
      match      = hit;
      dirty      = dty;
      req_valid  = 1'b1;
      hmem_ready = 1'($urandom_range(0, 1));
      check({tag, " idle before"}, 32'(o.busy), 0);

      while (!got_ready && cyc < 400) begin
         @(posedge clk);
         #1;
         cyc++;
         if (saw_fin) match = 1'b1;
         if (o.hrv) begin
            if (wait_cnt >= stall) begin
               hmem_ready = 1'b1;
               wait_cnt   = 0;
            end else begin
               hmem_ready = 1'b0;
               wait_cnt++;
            end
         end else begin
            hmem_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (cyc == 1) first_busy = o.busy;
         if (o.busy)       n_busy++;
         if (o.mrm)        n_mrm++;
         if (o.req_ready)  begin n_ready++; got_ready = 1; end
         if (o.pw)         n_pw++;
         if (o.set_dirty)  n_sd++;
         if (o.clr_dirty)  n_cd++;
         if (o.clr_valid)  n_cv++;
         if (o.fin)        n_fin++;
         if (o.set_addr)   n_sa++;
         if (o.use_victim) n_uv++;
         if (o.hrv && hmem_ready) got_x.push_back({o.hop, o.widx});
         saw_fin = o.fin;
      end
      check({tag, " completed"}, 32'(got_ready), 1);

      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      hmem_ready = 1'b0;
      check({tag, " idle after"}, 32'({o.busy, o.req_ready, o.hrv}), 0);
      check({tag, " accepted first edge"}, 32'(first_busy), 1);
      check({tag, " busy cycles"}, n_busy, busy_exp);
      check({tag, " recovery cycles"}, n_mrm, miss ? nxm * (stall + 1) : 0);
      check({tag, " req_ready count"}, n_ready, 1);
      check({tag, " perform_write"}, n_pw, 32'(op));
      check({tag, " set_dirty"}, n_sd, 32'(op && !wt));
      check({tag, " clear_dirty"}, n_cd, 32'(dwb));
      check({tag, " clear_valid"}, n_cv, 32'(miss));
      check({tag, " install"}, n_fin, 32'(miss));
      check({tag, " set_hmem_addr"}, n_sa, miss ? (dwb ? 2 : 1) : 0);
      check({tag, " use_victim"}, n_uv, 32'(dwb));
      check({tag, " xfer count"}, got_x.size(), exp_x.size());
      for (int i = 0; i < exp_x.size() && i < got_x.size(); i++)
         check($sformatf("%s xfer%0d", tag, i), 32'(got_x[i]), 32'(exp_x[i]));
   endtask

   initial begin
      bit found;
      rst_n      = 1'b0;
      sel        = 1'b0;
      req_valid  = 1'b0;
      req_op     = 1'b0;
      match      = 1'b0;
      dirty      = 1'b0;
      hmem_ready = 1'b0;
      #12;
      check("reset outs wb", 32'(o_wb), 0);
      check("reset outs wt", 32'(o_wt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post-reset idle", 32'(o_wb), 0);

      run_txn("read hit wb",        0, 0, 1, 0, 0);
      run_txn("write hit wb",       0, 1, 1, 1, 0);
      run_txn("dirty read miss",    0, 0, 0, 1, 0);
      run_txn("clean miss stall2",  0, 0, 0, 0, 2);
      run_txn("wt write hit dirty", 1, 1, 1, 1, 1);
      run_txn("wt write miss",      1, 1, 0, 1, 0);

      for (int n = 0; n < 24; n++)
         run_txn($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

      // Abort a fill at word 2 with an asynchronous reset.
      sel        = 1'b0;
      req_op     = 1'b0;
      match      = 1'b0;
      dirty      = 1'b0;
      req_valid  = 1'b1;
      hmem_ready = 1'b1;
      found      = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge clk);
         if (o.hrv && !o.hop && o.widx == 2'd2) found = 1'b1;
      end
      check("reached fill word 2", 32'(found), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset outs", 32'(o), 0);
      req_valid  = 1'b0;
      hmem_ready = 1'b0;
      @(posedge clk);
      #1;
      check("held in reset", 32'(o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("released idle", 32'(o), 0);
      run_txn("after reset read hit", 0, 0, 1, 0, 0);
      run_txn("after reset dirty miss", 0, 1, 0, 1, 1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
